// File: rtl/div_seq.sv
// Sequencer around an iterative unsigned divider core: accepts one request,
// restarts and enables the core for a fixed latency, then holds the quotient.
module div_seq #(
  parameter int C_NUM_BITS = 24,
  parameter int C_LATENCY  = 51
) (
  input  logic                  CK,
  input  logic                  RN,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [C_NUM_BITS-1:0] in_a,
  input  logic [C_NUM_BITS-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [C_NUM_BITS-1:0] out_q,
  output logic                  out_dbz,
  output logic                  busy,
  output logic                  div_rn,
  output logic                  div_e,
  output logic [C_NUM_BITS-1:0] div_a,
  output logic [C_NUM_BITS-1:0] div_b,
  input  logic [C_NUM_BITS-1:0] div_q
);

  localparam int CW = $clog2(C_LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Request sequencing, core control and result capture.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state   <= IDLE;
      cnt     <= '0;
      div_rn  <= 1'b0;
      div_e   <= 1'b0;
      div_a   <= '0;
      div_b   <= '0;
      out_q   <= '0;
      out_dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_a <= in_a;
            div_b <= in_b;
            if (in_b == '0) begin
              // Answered locally; the core is never released from reset.
              out_q   <= '1;
              out_dbz <= 1'b1;
              state   <= DONE;
            end else begin
              state <= CLR;
            end
          end
        end
        CLR: begin
          cnt    <= '0;
          div_rn <= 1'b1;
          div_e  <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            out_q   <= div_q;
            out_dbz <= 1'b0;
            div_e   <= 1'b0;
            div_rn  <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          div_rn <= 1'b0;
          div_e  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq with a behavioural divider core model.
module tb_div_seq;
  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, out_dbz, busy;
  logic        div_rn, div_e;
  logic [23:0] in_a, in_b, out_q, div_a, div_b, div_q;

  typedef struct {
    logic [23:0] q;
    logic        dbz;
    int          lat;
    logic [23:0] a;
    logic [23:0] b;
  } exp_t;

  exp_t sb[$];
  int   acc_hist[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  div_seq dut (
    .CK(CK), .RN(RN),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_dbz(out_dbz),
    .busy(busy), .div_rn(div_rn), .div_e(div_e), .div_a(div_a), .div_b(div_b),
    .div_q(div_q)
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  // Core model: quotient appears only after 50 enabled cycles out of reset.
  logic [23:0] core_q;
  int          core_cnt;
  always @(posedge CK) begin
    if (!div_rn) begin
      core_cnt <= 0;
      core_q   <= 24'h5A5A5A;
    end else if (div_e) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 49) core_q <= div_a / div_b;
    end
  end
  assign div_q = core_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t ref_div(input logic [23:0] a, input logic [23:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 24'd0) begin
      e.q = 24'hFFFFFF; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.dbz = 1'b0; e.lat = 53;
    end
    return e;
  endfunction

  // Monitor: pushes expectations on acceptance, pops and checks on result.
  int   acc_cyc = 0;
  int   ecount = 0;
  bit   rn_seen = 1'b0;
  bit   prev_valid = 1'b0;
  always @(negedge CK) begin
    if (!RN) begin
      prev_valid = 1'b0;
    end else begin
      if (div_e) ecount++;
      if (div_rn) rn_seen = 1'b1;
      if (in_valid && in_ready) begin
        sb.push_back(ref_div(in_a, in_b));
        acc_hist.push_back(cyc);
        acc_cyc = cyc;
        ecount  = 0;
        rn_seen = 1'b0;
      end
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", 32'(out_q), 32'(e.q));
          chk("dbz_flag", 32'(out_dbz), 32'(e.dbz));
          chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          chk("div_e_cycles", 32'(ecount), e.dbz ? 32'd0 : 32'd51);
          chk("op_a_stable", 32'(div_a), 32'(e.a));
          chk("op_b_stable", 32'(div_b), 32'(e.b));
          if (e.dbz) chk("dbz_core_in_reset", 32'(rn_seen), 32'd0);
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [23:0] a, input logic [23:0] b, input bit hold);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    do begin
      @(negedge CK);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge CK);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_ready);
    int n = 0;
    do begin
      @(posedge CK);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end while ((busy || out_valid) && n < 500);
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_out_dbz", 32'(out_dbz), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_div_rn", 32'(div_rn), 32'd0);
    chk("rst_div_e", 32'(div_e), 32'd0);
    chk("rst_div_ab", 32'({div_a, div_b}), 32'd0);
    RN = 1'b1;
    repeat (2) @(posedge CK);
    #1;

    send(24'd100, 24'd7, 1'b0);
    wait_idle(1'b0);
    chk("t1_q", 32'(out_q), 32'd14);

    send(24'h123456, 24'd0, 1'b0);
    wait_idle(1'b0);
    chk("dbz_q", 32'(out_q), 32'hFFFFFF);

    // Back-pressure: result held while the consumer stalls.
    out_ready = 1'b0;
    send(24'hFFFFFF, 24'd1, 1'b0);
    t0 = 0;
    while (!out_valid && t0 < 200) begin
      @(posedge CK); #1; t0++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge CK);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_q", 32'(out_q), 32'hFFFFFF);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      #1;
    end
    out_ready = 1'b1;
    @(posedge CK); #1;
    chk("bp_idle", 32'(in_ready), 32'd1);

    // Back-to-back with in_valid held high.
    send(24'd1000, 24'd10, 1'b1);
    send(24'd5, 24'd9, 1'b0);
    chk("b2b_spacing", 32'(acc_hist[$] - acc_hist[$-1]), 32'd54);
    wait_idle(1'b0);
    chk("b2b_q2", 32'(out_q), 32'd0);

    // Reset mid-run at counter 20.
    send(24'd777, 24'd3, 1'b0);
    repeat (21) @(posedge CK);
    #1;
    RN = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_div_rn", 32'(div_rn), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    @(posedge CK); #1;
    RN = 1'b1;
    @(posedge CK); #1;
    send(24'd81, 24'd9, 1'b0);
    wait_idle(1'b0);
    chk("post_rst_q", 32'(out_q), 32'd9);

    // Input activity while busy must not disturb the running request.
    send(24'd50000, 24'd123, 1'b0);
    repeat (10) @(posedge CK);
    #1;
    in_a = 24'd1; in_b = 24'd0;
    for (int i = 0; i < 8; i++) begin
      in_valid = ~in_valid;
      @(posedge CK); #1;
    end
    in_valid = 1'b0;
    chk("busy_div_a", 32'(div_a), 32'd50000);
    chk("busy_div_b", 32'(div_b), 32'd123);
    wait_idle(1'b0);
    chk("busy_q", 32'(out_q), 32'd406);

    // Randomised requests with random consumer stalls.
    for (int i = 0; i < 25; i++) begin
      logic [23:0] a, b;
      int mode;
      a = 24'($urandom);
      mode = $urandom_range(0, 4);
      if (mode == 0)      b = 24'd0;
      else if (mode == 1) b = 24'($urandom_range(1, 15));
      else                b = 24'($urandom) >> $urandom_range(0, 23);
      if (b == 24'd0 && mode != 0) b = 24'd1;
      send(a, b, 1'b0);
      wait_idle(1'b1);
    end

    repeat (5) @(posedge CK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
